// File: rtl/mgnt_pulse_seq.sv
// rtl/mgnt_pulse_seq.sv - multi-channel magnet charge/discharge pulse sequencer
// Pin outputs are registered from the current state, so they trail the state register by one cycle.
module mgnt_pulse_seq #(
  parameter int DW    = 32,
  parameter int NCH   = 2,
  parameter int GUARD = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  input  logic           ABORT,
  input  logic           CONT,
  input  logic [NCH-1:0] EN_MASK,
  input  logic [DW-1:0]  CHG_PLEN,
  input  logic [DW-1:0]  CHG_DLEN,
  input  logic [DW-1:0]  DCHG_PLEN,
  input  logic [DW-1:0]  DCHG_DLEN,
  input  logic [DW-1:0]  N,
  input  logic [DW-1:0]  D,
  output logic [NCH-1:0] CHG_OUT,
  output logic [NCH-1:0] DCHG_OUT,
  output logic           BUSY,
  output logic           DONE,
  output logic           ABORTED,
  output logic [DW-1:0]  REP_CNT
);

  typedef enum logic [2:0] {IDLE, LOAD, CHG, CDLY, DCHG, DDLY, POST, FIN} state_t;

  localparam logic [DW-1:0] GUARD_W = DW'(GUARD);
  localparam logic [DW-1:0] ONE     = DW'(1);

  state_t         state;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  chg_plen_q, chg_dly_q, dchg_plen_q, dchg_dly_q, n_q, d_q;
  logic [NCH-1:0] mask_q;
  logic           cont_q;
  logic           fin_new;

  // Delay phases never shrink below the dead time between the two pulse polarities.
  function automatic logic [DW-1:0] guarded(input logic [DW-1:0] len);
    return (len < GUARD_W) ? GUARD_W : len;
  endfunction

  logic [DW-1:0] cp_src, cd_src, d_src, chg_cnt, rep_inc;
  state_t        chg_st, post_st;
  logic          last, more;

  // In LOAD the latches are not yet valid, so entry decisions look at the live inputs.
  always_comb begin
    cp_src  = (state == LOAD) ? CHG_PLEN : chg_plen_q;
    cd_src  = (state == LOAD) ? guarded(CHG_DLEN) : chg_dly_q;
    d_src   = (state == LOAD) ? D : d_q;
    chg_st  = (cp_src == '0) ? CDLY : CHG;
    chg_cnt = (cp_src == '0) ? cd_src : cp_src;
    post_st = (d_src == '0) ? FIN : POST;
    rep_inc = (&REP_CNT) ? REP_CNT : REP_CNT + ONE;
    last    = (cnt == ONE);
    more    = cont_q ? START : (({1'b0, REP_CNT} + (DW+1)'(1)) < {1'b0, n_q});
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      chg_plen_q  <= '0;
      chg_dly_q   <= '0;
      dchg_plen_q <= '0;
      dchg_dly_q  <= '0;
      n_q         <= '0;
      d_q         <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      fin_new     <= 1'b0;
      CHG_OUT     <= '0;
      DCHG_OUT    <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ABORTED     <= 1'b0;
      REP_CNT     <= '0;
    end else begin
      CHG_OUT  <= (state == CHG && !ABORT) ? mask_q : '0;
      DCHG_OUT <= (state == DCHG && !ABORT) ? mask_q : '0;
      BUSY     <= (state != IDLE);
      DONE     <= (state == FIN) && fin_new;
      fin_new  <= 1'b0;
      if (ABORT && state != IDLE && state != FIN) begin
        ABORTED <= 1'b1;
        state   <= FIN;
        fin_new <= 1'b1;
      end else begin
        case (state)
          IDLE: if (START) state <= LOAD;
          LOAD: begin
            chg_plen_q  <= CHG_PLEN;
            chg_dly_q   <= guarded(CHG_DLEN);
            dchg_plen_q <= DCHG_PLEN;
            dchg_dly_q  <= guarded(DCHG_DLEN);
            n_q         <= N;
            d_q         <= D;
            mask_q      <= EN_MASK;
            cont_q      <= CONT;
            REP_CNT     <= '0;
            ABORTED     <= 1'b0;
            if (!CONT && N == '0) begin
              state   <= post_st;
              cnt     <= d_src;
              fin_new <= (post_st == FIN);
            end else begin
              state <= chg_st;
              cnt   <= chg_cnt;
            end
          end
          CHG: begin
            if (last) begin
              state <= CDLY;
              cnt   <= chg_dly_q;
            end else cnt <= cnt - ONE;
          end
          CDLY: begin
            if (last) begin
              state <= (dchg_plen_q == '0) ? DDLY : DCHG;
              cnt   <= (dchg_plen_q == '0) ? dchg_dly_q : dchg_plen_q;
            end else cnt <= cnt - ONE;
          end
          DCHG: begin
            if (last) begin
              state <= DDLY;
              cnt   <= dchg_dly_q;
            end else cnt <= cnt - ONE;
          end
          DDLY: begin
            if (last) begin
              REP_CNT <= rep_inc;
              if (more) begin
                state <= chg_st;
                cnt   <= chg_cnt;
              end else begin
                state   <= post_st;
                cnt     <= d_src;
                fin_new <= (post_st == FIN);
              end
            end else cnt <= cnt - ONE;
          end
          POST: begin
            if (last) begin
              state   <= FIN;
              fin_new <= 1'b1;
            end else cnt <= cnt - ONE;
          end
          FIN: begin
            if (ABORT) ABORTED <= 1'b1;
            if (!START) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mgnt_pulse_seq.sv
// tb/tb_mgnt_pulse_seq.sv - scoreboard bench for mgnt_pulse_seq
// Expected pin waveforms are generated from the phase lengths and compared one sample per cycle.
module tb_mgnt_pulse_seq;
  localparam int DW    = 8;
  localparam int NCH   = 2;
  localparam int GUARD = 2;

  logic           CLK = 1'b0;
  logic           RESET, START, ABORT, CONT;
  logic [NCH-1:0] EN_MASK;
  logic [DW-1:0]  CHG_PLEN, CHG_DLEN, DCHG_PLEN, DCHG_DLEN, N, D;
  logic [NCH-1:0] CHG_OUT, DCHG_OUT;
  logic           BUSY, DONE, ABORTED;
  logic [DW-1:0]  REP_CNT;

  mgnt_pulse_seq #(.DW(DW), .NCH(NCH), .GUARD(GUARD)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .CONT(CONT),
    .EN_MASK(EN_MASK), .CHG_PLEN(CHG_PLEN), .CHG_DLEN(CHG_DLEN),
    .DCHG_PLEN(DCHG_PLEN), .DCHG_DLEN(DCHG_DLEN), .N(N), .D(D),
    .CHG_OUT(CHG_OUT), .DCHG_OUT(DCHG_OUT), .BUSY(BUSY), .DONE(DONE),
    .ABORTED(ABORTED), .REP_CNT(REP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NCH-1:0] chg;
    logic [NCH-1:0] dchg;
    logic           busy;
    logic           done;
    logic           ab;
  } samp_t;

  typedef struct {
    int cp; int cd; int dp; int dd; int n; int d;
    logic [NCH-1:0] mask;
    int rep;
  } vec_t;

  samp_t exp_q[$];
  vec_t  vecs[7];
  int    checks = 0;
  int    errors = 0;
  int    last_kind = 0;
  int    gap = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int g(input int x);
    return (x < GUARD) ? GUARD : x;
  endfunction

  task automatic push(input logic [NCH-1:0] c, input logic [NCH-1:0] dc,
                      input logic b, input logic dn, input logic ab);
    samp_t s;
    s.chg = c; s.dchg = dc; s.busy = b; s.done = dn; s.ab = ab;
    exp_q.push_back(s);
  endtask

  // One sample per state cycle, starting with the cycle the START edge leaves IDLE.
  task automatic push_run(input vec_t v, input logic prev_ab, input bit tail);
    push('0, '0, 1'b0, 1'b0, prev_ab);
    push('0, '0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < v.n; r++) begin
      repeat (v.cp)    push(v.mask, '0, 1'b1, 1'b0, 1'b0);
      repeat (g(v.cd)) push('0, '0, 1'b1, 1'b0, 1'b0);
      repeat (v.dp)    push('0, v.mask, 1'b1, 1'b0, 1'b0);
      repeat (g(v.dd)) push('0, '0, 1'b1, 1'b0, 1'b0);
    end
    repeat (v.d) push('0, '0, 1'b1, 1'b0, 1'b0);
    push('0, '0, 1'b1, 1'b1, 1'b0);
    if (tail) push('0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_run(input vec_t v);
    @(negedge CLK);
    CHG_PLEN = DW'(v.cp); CHG_DLEN = DW'(v.cd);
    DCHG_PLEN = DW'(v.dp); DCHG_DLEN = DW'(v.dd);
    N = DW'(v.n); D = DW'(v.d); EN_MASK = v.mask;
    START = 1'b1;
  endtask

  task automatic run_cmp(input int start_drop, input int abort_at, input int stop_at);
    int idx = 0;
    samp_t e;
    @(posedge CLK);
    while (exp_q.size() > 0 && idx < stop_at) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      check($sformatf("s%0d chg", idx), int'(CHG_OUT), int'(e.chg));
      check($sformatf("s%0d dchg", idx), int'(DCHG_OUT), int'(e.dchg));
      check($sformatf("s%0d busy", idx), int'(BUSY), int'(e.busy));
      check($sformatf("s%0d done", idx), int'(DONE), int'(e.done));
      check($sformatf("s%0d aborted", idx), int'(ABORTED), int'(e.ab));
      if (idx == start_drop) START = 1'b0;
      ABORT = (idx == abort_at);
      idx++;
    end
  endtask

  // Independent dead-time / overlap monitor on the pins.
  always @(negedge CLK) begin
    if (RESET) begin
      last_kind = 0;
      gap = 0;
    end else begin
      if (CHG_OUT != '0 || DCHG_OUT != '0)
        check("overlap", int'(CHG_OUT != '0 && DCHG_OUT != '0), 0);
      if (CHG_OUT != '0 && last_kind == 2) check("guard dchg->chg", int'(gap >= GUARD), 1);
      if (DCHG_OUT != '0 && last_kind == 1) check("guard chg->dchg", int'(gap >= GUARD), 1);
      if (CHG_OUT != '0) begin last_kind = 1; gap = 0; end
      else if (DCHG_OUT != '0) begin last_kind = 2; gap = 0; end
      else gap++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int w;
    vecs[0] = '{3, 4, 2, 4, 2, 5, 2'b11, 2};
    vecs[1] = '{3, 0, 2, 0, 3, 0, 2'b11, 3};
    vecs[2] = '{0, 1, 2, 3, 2, 1, 2'b10, 2};
    vecs[3] = '{3, 4, 2, 4, 0, 4, 2'b11, 0};
    vecs[4] = '{0, 0, 0, 0, 2, 0, 2'b01, 2};
    vecs[5] = '{255, 255, 255, 255, 1, 255, 2'b11, 1};
    vecs[6] = '{1, 0, 1, 0, 1, 0, 2'b01, 1};

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; CONT = 1'b0; EN_MASK = '0;
    CHG_PLEN = '0; CHG_DLEN = '0; DCHG_PLEN = '0; DCHG_DLEN = '0; N = '0; D = '0;
    repeat (2) @(negedge CLK);
    check("reset chg", int'(CHG_OUT), 0);
    check("reset dchg", int'(DCHG_OUT), 0);
    check("reset busy", int'(BUSY), 0);
    check("reset done", int'(DONE), 0);
    check("reset aborted", int'(ABORTED), 0);
    check("reset rep", int'(REP_CNT), 0);
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i]);
      push_run(vecs[i], 1'b0, 1'b1);
      run_cmp(0, -1, 1 << 30);
      check($sformatf("vec%0d rep", i), int'(REP_CNT), vecs[i].rep);
      check($sformatf("vec%0d aborted", i), int'(ABORTED), 0);
    end

    // abort in the middle of a 10-cycle charge pulse
    v = '{10, 4, 2, 4, 2, 5, 2'b11, 0};
    start_run(v);
    push('0, '0, 1'b0, 1'b0, 1'b0);
    push('0, '0, 1'b1, 1'b0, 1'b0);
    push(2'b11, '0, 1'b1, 1'b0, 1'b0);
    push(2'b11, '0, 1'b1, 1'b0, 1'b0);
    push('0, '0, 1'b1, 1'b0, 1'b1);
    push('0, '0, 1'b1, 1'b1, 1'b1);
    push('0, '0, 1'b0, 1'b0, 1'b1);
    run_cmp(0, 3, 1 << 30);
    check("abort rep", int'(REP_CNT), 0);

    @(negedge CLK);
    ABORT = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("idle abort busy", int'(BUSY), 0);
      check("idle abort sticky", int'(ABORTED), 1);
    end
    ABORT = 1'b0;

    // START and ABORT together in IDLE: the run proceeds and ABORTED clears at LOAD
    start_run(vecs[0]);
    ABORT = 1'b1;
    push_run(vecs[0], 1'b1, 1'b1);
    run_cmp(0, -1, 1 << 30);
    check("start+abort rep", int'(REP_CNT), 2);
    check("start+abort aborted", int'(ABORTED), 0);

    // START held through FIN: no retrigger, exit only once START drops
    start_run(vecs[6]);
    push_run(vecs[6], 1'b0, 1'b0);
    run_cmp(-1, -1, 1 << 30);
    repeat (6) begin
      @(negedge CLK);
      check("hold busy", int'(BUSY), 1);
      check("hold chg", int'(CHG_OUT), 0);
      check("hold dchg", int'(DCHG_OUT), 0);
      check("hold done", int'(DONE), 0);
    end
    START = 1'b0;
    @(negedge CLK);
    check("hold release busy1", int'(BUSY), 1);
    @(negedge CLK);
    check("hold release busy0", int'(BUSY), 0);
    check("hold rep", int'(REP_CNT), 1);

    // continuous mode, N=1, START dropped during the third repetition
    v = '{1, 0, 1, 0, 3, 3, 2'b11, 3};
    start_run(v);
    CONT = 1'b1;
    N = DW'(1);
    push_run(v, 1'b0, 1'b1);
    run_cmp(15, -1, 1 << 30);
    check("cont rep", int'(REP_CNT), 3);
    CONT = 1'b0;

    // reset mid-discharge with only channel 0 enabled
    v = '{3, 4, 2, 4, 2, 5, 2'b01, 2};
    start_run(v);
    push_run(v, 1'b0, 1'b1);
    run_cmp(0, -1, 10);
    #2 RESET = 1'b1;
    #1;
    check("async reset dchg", int'(DCHG_OUT), 0);
    check("async reset chg", int'(CHG_OUT), 0);
    check("async reset busy", int'(BUSY), 0);
    check("async reset rep", int'(REP_CNT), 0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("post reset busy", int'(BUSY), 0);
      check("post reset dchg", int'(DCHG_OUT), 0);
    end

    // REP_CNT saturation in continuous mode
    v = '{1, 0, 1, 0, 1, 0, 2'b11, 0};
    start_run(v);
    CONT = 1'b1;
    repeat (1800) @(negedge CLK);
    START = 1'b0;
    w = 0;
    while (BUSY !== 1'b0 && w < 60) begin
      @(negedge CLK);
      w++;
    end
    check("sat busy drop", int'(w < 60), 1);
    check("sat rep", int'(REP_CNT), 255);
    CONT = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
